// File: rtl/axis_src_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_src_pkg
// Description : Shared types and helpers for the AXI4-Stream replay source:
//               FSM state encoding, byte-lane width helpers and the per-lane
//               TKEEP generator for the partial final beat.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_src_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Number of byte lanes in a data word.
    function automatic int keep_w(input int data_w);
        return data_w / 8;
    endfunction

    // Width of the last-beat byte count; at least one bit so the port exists.
    function automatic int lb_w(input int data_w);
        return (data_w / 8 > 1) ? $clog2(data_w / 8) : 1;
    endfunction

    // One lane of the final-beat keep mask: 0 selects every lane,
    // otherwise the low last_bytes lanes are kept.
    function automatic logic keep_bit(input int unsigned last_bytes,
                                      input int unsigned lane);
        return (last_bytes == 0) || (lane < last_bytes);
    endfunction

endpackage : axis_src_pkg
`default_nettype wire

// File: rtl/axis_src_ram.sv
`default_nettype none
// ============================================================================
// Module      : axis_src_ram
// Description : Simple dual-port word buffer, synchronous write and
//               registered read. A same-address write and read in one cycle
//               returns the old contents (read-before-write).
// Revision    : 1.0 - initial release
// ============================================================================
module axis_src_ram
    import axis_src_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write port and registered read port; no reset so it maps to block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule : axis_src_ram
`default_nettype wire

// File: rtl/axis_stream_src.sv
`default_nettype none
// ============================================================================
// Module      : axis_stream_src
// Description : AXI4-Stream master replay source. A host fills the buffer,
//               then START streams LEN words from address 0 with TLAST on
//               the final beat, full TREADY backpressure through a 2-entry
//               skid and a partial TKEEP/TSTRB on the final beat.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_stream_src
    import axis_src_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 10,
    localparam int KEEP_W = keep_w(DATA_W),
    localparam int LB_W   = lb_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [LB_W-1:0]   last_bytes,
    output logic              busy,
    output logic              done,
    output logic              axis_tclk,
    output logic [DATA_W-1:0] axis_tdata,
    output logic [KEEP_W-1:0] axis_tkeep,
    output logic [KEEP_W-1:0] axis_tstrb,
    output logic              axis_tlast,
    output logic              axis_tvalid,
    input  logic              axis_tready
);

    localparam logic [ADDR_W:0] CNT_ONE = 1;
    localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};

    state_t            r_state;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [ADDR_W:0]   r_sent;
    logic [KEEP_W-1:0] r_last_keep;
    logic              r_busy;
    logic              r_done;

    logic [DATA_W-1:0] r_skid0;
    logic [DATA_W-1:0] r_skid1;
    logic [1:0]        r_count;
    logic              r_pend;

    logic [DATA_W-1:0] w_rd_data;
    logic [KEEP_W-1:0] w_last_keep;
    logic [ADDR_W:0]   w_len_clamped;
    logic              w_valid;
    logic              w_pop;
    logic              w_last;
    logic [2:0]        w_occ;
    logic              w_rd_en;
    logic              w_slot1;

    axis_src_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (w_rd_en),
        .rd_addr (r_rd_ptr[ADDR_W-1:0]),
        .rd_data (w_rd_data)
    );

    // Final-beat keep mask built lane by lane from the requested byte count.
    always_comb begin
        w_last_keep = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            w_last_keep[i] = keep_bit(32'(last_bytes), i);
        end
    end

    // Lengths above the buffer depth are clamped to one full pass.
    assign w_len_clamped = len[ADDR_W] ? DEPTH : len;

    // Beat qualifiers come only from registers, never from TREADY.
    assign w_valid = (r_count != 2'd0);
    assign w_pop   = w_valid & axis_tready;
    assign w_last  = w_valid && (r_sent == r_len - CNT_ONE);

    // Occupancy the skid will have next cycle, assuming no pop then; a new
    // read is only launched when its data is guaranteed a slot on arrival.
    assign w_occ   = {1'b0, r_count} - {2'b00, w_pop} + {2'b00, r_pend};
    assign w_rd_en = (r_state == PRIME) ||
                     ((r_state == STREAM) && (r_rd_ptr < r_len) && (w_occ <= 3'd1));

    // Arriving word goes behind whatever survives this cycle's pop.
    assign w_slot1 = ((r_count - {1'b0, w_pop}) != 2'd0);

    // Control FSM with counters and registered BUSY/DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_rd_ptr    <= '0;
            r_sent      <= '0;
            r_last_keep <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + CNT_ONE;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (len == '0) begin
                            r_state <= FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_len       <= w_len_clamped;
                            r_last_keep <= w_last_keep;
                            r_rd_ptr    <= '0;
                            r_sent      <= '0;
                            r_state     <= PRIME;
                        end
                    end
                end
                PRIME: begin
                    r_state <= STREAM;
                end
                STREAM: begin
                    if (w_pop) begin
                        r_sent <= r_sent + CNT_ONE;
                        if (w_last) begin
                            r_state <= FINISH;
                            r_done  <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Two-entry output skid: head in slot 0, RAM data lands one cycle after its read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid0 <= '0;
            r_skid1 <= '0;
            r_count <= 2'd0;
            r_pend  <= 1'b0;
        end else begin
            r_pend  <= w_rd_en;
            r_count <= r_count - {1'b0, w_pop} + {1'b0, r_pend};
            if (w_pop) begin
                r_skid0 <= r_skid1;
            end
            if (r_pend) begin
                if (w_slot1) begin
                    r_skid1 <= w_rd_data;
                end else begin
                    r_skid0 <= w_rd_data;
                end
            end
        end
    end

    assign axis_tclk   = clk;
    assign axis_tvalid = w_valid;
    assign axis_tdata  = w_valid ? r_skid0 : '0;
    assign axis_tlast  = w_last;
    assign axis_tkeep  = w_valid ? (w_last ? r_last_keep : {KEEP_W{1'b1}}) : '0;
    assign axis_tstrb  = axis_tkeep;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule : axis_stream_src
`default_nettype wire

// File: tb/tb_axis_stream_src.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_stream_src
// Description : Scoreboard bench for axis_stream_src (DATA_W=32, ADDR_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_stream_src;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len = '0;
    logic [1:0]        last_bytes = '0;
    logic              busy;
    logic              done;
    logic              axis_tclk;
    logic [DATA_W-1:0] axis_tdata;
    logic [3:0]        axis_tkeep;
    logic [3:0]        axis_tstrb;
    logic              axis_tlast;
    logic              axis_tvalid;
    logic              axis_tready = 1'b0;

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    done_cnt = 0;
    bit    rnd_mode = 1'b0;
    bit    ready_fixed = 1'b1;
    bit    exp_done_next = 1'b0;
    bit    stall_prev = 1'b0;
    logic [37:0] stall_saved = '0;
    logic [31:0] model [DEPTH];
    beat_t exp_q [$];
    int    hs_cyc [$];

    axis_stream_src #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .len         (len),
        .last_bytes  (last_bytes),
        .busy        (busy),
        .done        (done),
        .axis_tclk   (axis_tclk),
        .axis_tdata  (axis_tdata),
        .axis_tkeep  (axis_tkeep),
        .axis_tstrb  (axis_tstrb),
        .axis_tlast  (axis_tlast),
        .axis_tvalid (axis_tvalid),
        .axis_tready (axis_tready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycle counter and sink ready generator (changes just after the edge).
    always @(posedge clk) begin
        cyc++;
        #1;
        axis_tready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    // Output monitor: scoreboard compare, DONE timing and AXIS hold rule.
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            stall_prev    = 1'b0;
            exp_done_next = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (exp_done_next) begin
                check("done_pulse", 64'(done), 64'd1);
                exp_done_next = 1'b0;
            end
            if (stall_prev)
                check("stall_hold", 64'({axis_tvalid, axis_tdata, axis_tkeep, axis_tlast}),
                      64'(stall_saved));
            if (axis_tvalid && axis_tready) begin
                check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("tdata", 64'(axis_tdata), 64'(e.data));
                    check("tkeep", 64'(axis_tkeep), 64'(e.keep));
                    check("tstrb", 64'(axis_tstrb), 64'(e.keep));
                    check("tlast", 64'(axis_tlast), 64'(e.last));
                    if (e.last) exp_done_next = 1'b1;
                end
                hs_cyc.push_back(cyc);
            end
            stall_prev  = axis_tvalid && !axis_tready;
            stall_saved = {axis_tvalid, axis_tdata, axis_tkeep, axis_tlast};
        end
    end

    task automatic write_word(input int addr, input logic [31:0] data);
        @(posedge clk); #1;
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(addr);
        wr_data = data;
        @(posedge clk); #1;
        wr_en   = 1'b0;
        model[addr] = data;
    endtask

    // Pulse START and push the beats the sink should see.
    task automatic start_stream(input int n, input int lb);
        int    eff;
        beat_t b;
        @(posedge clk); #1;
        start      = 1'b1;
        len        = (ADDR_W + 1)'(n);
        last_bytes = 2'(lb);
        eff = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < eff; i++) begin
            b.data = model[i];
            b.last = (i == eff - 1);
            b.keep = (b.last && lb != 0) ? 4'((1 << lb) - 1) : 4'hF;
            exp_q.push_back(b);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (!busy && exp_q.size() == 0) break;
        end
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int d0;
        bit found;

        #2;
        check("rst_busy",   64'(busy),        64'd0);
        check("rst_done",   64'(done),        64'd0);
        check("rst_tvalid", 64'(axis_tvalid), 64'd0);
        check("rst_tlast",  64'(axis_tlast),  64'd0);
        check("rst_tdata",  64'(axis_tdata),  64'd0);
        check("rst_tkeep",  64'(axis_tkeep),  64'd0);
        check("rst_tstrb",  64'(axis_tstrb),  64'd0);
        #20;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) write_word(i, 32'h1000 + i);

        // Eight beats with TREADY high: latency, no bubbles, one DONE.
        hs_cyc.delete();
        d0 = done_cnt;
        start_stream(8, 0);
        @(negedge clk); check("lat_prime_tvalid", 64'(axis_tvalid), 64'd0);
        @(negedge clk); check("lat_fetch_tvalid", 64'(axis_tvalid), 64'd0);
        @(negedge clk); check("lat_first_tvalid", 64'(axis_tvalid), 64'd1);
        wait_idle("len8", 100);
        check("len8_beats", 64'(hs_cyc.size()), 64'd8);
        if (hs_cyc.size() == 8)
            check("len8_no_bubbles", 64'(hs_cyc[7] - hs_cyc[0]), 64'd7);
        check("len8_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Sixteen beats under random backpressure.
        hs_cyc.delete();
        rnd_mode = 1'b1;
        start_stream(16, 0);
        wait_idle("len16_bp", 300);
        rnd_mode = 1'b0;
        check("len16_beats", 64'(hs_cyc.size()), 64'd16);

        // Partial final beat.
        hs_cyc.delete();
        start_stream(3, 1);
        wait_idle("len3_lb1", 100);
        check("len3_beats", 64'(hs_cyc.size()), 64'd3);

        // Zero length: BUSY and DONE for one cycle, no beats.
        hs_cyc.delete();
        d0 = done_cnt;
        start_stream(0, 0);
        @(negedge clk); #1;
        check("len0_busy",   64'(busy),        64'd1);
        check("len0_done",   64'(done),        64'd1);
        check("len0_tvalid", 64'(axis_tvalid), 64'd0);
        @(negedge clk); #1;
        check("len0_busy_end", 64'(busy), 64'd0);
        check("len0_done_end", 64'(done), 64'd0);
        check("len0_beats",    64'(hs_cyc.size()), 64'd0);
        check("len0_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Over-length request is clamped to the buffer depth.
        hs_cyc.delete();
        start_stream(DEPTH + 5, 0);
        wait_idle("len_over", 200);
        check("len_over_beats", 64'(hs_cyc.size()), 64'(DEPTH));

        // Reset after the fourth beat, then a fresh short stream.
        hs_cyc.delete();
        start_stream(10, 0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (hs_cyc.size() >= 4) break;
        end
        check("rst_mid_reach4", 64'(hs_cyc.size()), 64'd4);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rstm_tvalid", 64'(axis_tvalid), 64'd0);
        check("rstm_tlast",  64'(axis_tlast),  64'd0);
        check("rstm_tdata",  64'(axis_tdata),  64'd0);
        check("rstm_tkeep",  64'(axis_tkeep),  64'd0);
        check("rstm_busy",   64'(busy),        64'd0);
        check("rstm_done",   64'(done),        64'd0);
        check("rstm_left",   64'(exp_q.size()), 64'd6);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        check("rstm_wait_idle", 64'(busy), 64'd0);
        hs_cyc.delete();
        start_stream(2, 0);
        wait_idle("post_rst", 100);
        check("post_rst_beats", 64'(hs_cyc.size()), 64'd2);

        // START during STREAM and on the DONE cycle must be ignored.
        hs_cyc.delete();
        d0 = done_cnt;
        rnd_mode = 1'b1;
        start_stream(8, 0);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; len = 5'd5;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        check("ign_done_seen", 64'(found), 64'd1);
        start = 1'b1; len = 5'd4;
        @(posedge clk); #1;
        start = 1'b0;
        rnd_mode = 1'b0;
        wait_idle("ign", 100);
        repeat (6) @(negedge clk);
        #1;
        check("ign_still_idle", 64'(busy),            64'd0);
        check("ign_beats",      64'(hs_cyc.size()),   64'd8);
        check("ign_done_cnt",   64'(done_cnt - d0),   64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_axis_stream_src
`default_nettype wire

// File: doc/axis_stream_src.md
# axis_stream_src

Parametrised AXI4-Stream master source: a host loads words into an internal buffer through a simple write port, then issues START with a length. The block streams the words out from address 0 upward and asserts TLAST on the final beat. Unlike the earlier task-driven source, it fully honours TREADY backpressure, sustains one beat per cycle, and supports configurable data width and depth. It also drives per-byte TKEEP/TSTRB with a partial final beat. It sits at the head of the stream test and reduce datapaths as the stimulus/replay engine.

## Interface
- DATA_W, default 32: stream data width in bits; multiple of 8, minimum 8.
- ADDR_W, default 10: buffer address width; depth = 2^ADDR_W words.
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- WR_EN  in  1  buffer write strobe.
- WR_ADDR  in  ADDR_W  buffer write address.
- WR_DATA  in  DATA_W  buffer write data.
- START  in  1  single-cycle stream request; sampled only in IDLE.
- LEN  in  ADDR_W+1  beats to send; sampled with START.
- LAST_BYTES  in  $clog2(DATA_W/8)  valid bytes in the final beat; 0 means all bytes. Sampled with START.
- BUSY  out  1  stream in progress.
- DONE  out  1  one-cycle pulse after the final handshake.
- AXIS_TCLK  out  1  equals CLK.
- AXIS_TDATA  out  DATA_W  stream data.
- AXIS_TKEEP  out  DATA_W/8  byte qualifier.
- AXIS_TSTRB  out  DATA_W/8  equals AXIS_TKEEP.
- AXIS_TLAST  out  1  final beat marker.
- AXIS_TVALID  out  1  beat valid.
- AXIS_TREADY  in  1  sink ready.

## Operation
- FSM states: IDLE, PRIME, STREAM, FINISH.
- IDLE:
  - START with LEN=0 goes to FINISH; no beats are sent.
  - START with LEN>0 latches len_q = min(LEN, 2^ADDR_W) and LAST_BYTES, clears rd_ptr and sent counters, then goes to PRIME.
  - START outside IDLE is ignored.
- PRIME:
  - Issues the read of address 0, then goes to STREAM.
  - The buffer has a one-cycle synchronous read.
- STREAM:
  - A 2-entry output skid register holds fetched words.
  - A read is issued whenever fewer than len_q words have been fetched and the skid will have a free slot next cycle.
  - A handshake is TVALID&&TREADY. Each handshake advances the sent counter.
  - TLAST=1 on the beat where sent == len_q-1.
  - After the handshake of the TLAST beat, go to FINISH.
- FINISH: DONE=1 for one cycle, then IDLE.
- BUSY=1 in PRIME, STREAM and FINISH.
- TKEEP/TSTRB:
  - All ones on every beat except the last.
  - Last beat: low LAST_BYTES bits set when LAST_BYTES≠0, otherwise all ones.
- When TVALID=0, TDATA/TKEEP/TSTRB/TLAST are driven to 0.
- Writes are accepted in any state, and a write and a read of the same address in one cycle return the old data. Writes during STREAM to addresses not yet fetched appear in the stream; writes to already-fetched addresses do not.
- Counters are ADDR_W+1 bits wide. A full-depth stream reads addresses 0..2^ADDR_W-1 with no wrap to 0.

## Timing
- Reset values, applied asynchronously the moment RST_N is low:
  - Outputs: BUSY, DONE, TVALID, TLAST, TDATA, TKEEP and TSTRB are 0.
  - FSM returns to IDLE.
  - Buffer contents are undefined after reset.
- Reset mid-stream drops TVALID immediately with no TLAST. After release the block waits for a new START.
- Latency: START sampled at edge N gives PRIME at N+1, the first read data at N+2, and TVALID=1 after edge N+2.
- With TREADY held high, the block delivers len_q beats on consecutive cycles with no bubbles.
- AXIS rule: once TVALID=1, TVALID, TDATA, TKEEP and TLAST hold stable until the handshake.
- TVALID never depends combinationally on TREADY.
- DONE is high in the cycle after the final handshake edge. BUSY falls together with DONE.
- A START coincident with the DONE cycle is ignored. The earliest accepted restart is the cycle after DONE.

## Structure
- Package axis_src_pkg holds:
  - the state enum (IDLE, PRIME, STREAM, FINISH);
  - the localparam functions KEEP_W = DATA_W/8 and the keep-mask generator from LAST_BYTES.
- Sub-module axis_src_ram holds the buffer: simple dual-port, sync write, registered read, DATA_W × 2^ADDR_W, so it infers block RAM.
- Top level holds the FSM, counters and the 2-entry skid.

## Test plan
- Load ram[i]=0x1000+i, START LEN=8, TREADY=1: 8 consecutive beats 0x1000..0x1007, TLAST only on 0x1007, TKEEP=0xF, DONE one cycle after the last beat.
- Same load, LEN=16, TREADY toggling 1,0,0,1 pseudo-randomly:
  - exactly 16 beats in order, no loss or duplication;
  - TDATA stable whenever TVALID=1 and TREADY=0.
- LEN=3, LAST_BYTES=1 (DATA_W=32): beats 0 and 1 carry TKEEP=TSTRB=0xF; beat 2 carries 0x1 with TLAST=1.
- LEN=0: no TVALID; BUSY for one cycle; DONE pulse at N+1. LEN=2^ADDR_W+5: exactly 2^ADDR_W beats.
- RST_N low after beat 4 of LEN=10 with TREADY=1:
  - all outputs 0 immediately;
  - after release, START LEN=2 gives beats ram[0], ram[1].
- START pulsed during STREAM and on the DONE cycle: ignored, with no extra beats and no extra DONE.
